// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: instruction-fetch front end.
// A PC generator issues word-aligned icache reads. Each read returns one cycle later.
// Returned words go into a DEPTH-entry prefetch FIFO that decode drains with out_valid/out_ready.
// A branch/jump redirect flushes every queued fetch and every in-flight fetch.
//
// Optional build macro: FETCH_BYPASS_EN. When it is defined, a response that arrives while the
// FIFO is empty drives out_* in the same cycle.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   icache_addr/re  fetch request; the word arrives on instruction one cycle later
//   instruction     icache read data
//   redirect_valid  taken branch/jump; redirect_pc is the target (bits [1:0] ignored)
//   out_valid/ready head-entry handshake towards decode
//   out_inst/pc     head instruction and its PC
//   fq_count        FIFO occupancy
module riscv_fetch_queue #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [ADDR_W-1:0]        icache_addr,
   output logic                     icache_re,
   input  logic [DATA_W-1:0]        instruction,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_inst,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [$clog2(DEPTH):0]   fq_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_infl_pc;
   logic              r_inflight;
   logic              r_infl_epoch;
   logic              r_epoch;
   logic [DATA_W-1:0] r_mem_inst [DEPTH];
   logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic [ADDR_W-1:0] w_redir_addr;
   logic              w_credit_ok;
   logic              w_issue;
   logic              w_resp;
   logic              w_empty;
   logic              w_bypass;
   logic              w_fifo_pop;
   logic              w_push;
   logic              w_unused;

   assign w_unused     = ^redirect_pc[1:0];
   assign w_redir_addr = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign w_empty      = (r_count == '0);

   // Credits come from registered state only. A pop in this cycle does not free a slot until the
   // next cycle.
   assign w_credit_ok  = (r_count + CNT_W'(r_inflight)) < DEPTH_C;
   assign w_issue      = ~rst & (redirect_valid | w_credit_ok);

   // A response tagged with a stale epoch belongs to a flushed stream.
   // A redirect in the response cycle also kills the response.
   assign w_resp       = ~rst & r_inflight & (r_infl_epoch == r_epoch) & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
   assign w_bypass     = w_resp & w_empty;
`else
   assign w_bypass     = 1'b0;
`endif

   assign w_fifo_pop   = ~w_empty & out_ready & ~redirect_valid;
   // A bypassed word that decode accepts never enters the FIFO.
   assign w_push       = w_resp & ~(w_bypass & out_ready);

   always_comb begin
      icache_re   = w_issue;
      icache_addr = redirect_valid ? w_redir_addr : r_fetch_pc;
      out_valid   = ~rst & (~w_empty | w_bypass);
      out_inst    = w_bypass ? instruction : r_mem_inst[r_rd_ptr];
      out_pc      = w_bypass ? r_infl_pc   : r_mem_pc[r_rd_ptr];
      fq_count    = rst ? '0 : r_count;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc   <= RESET_PC;
         r_infl_pc    <= '0;
         r_inflight   <= 1'b0;
         r_infl_epoch <= 1'b0;
         r_epoch      <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_infl_pc    <= icache_addr;
            r_infl_epoch <= redirect_valid ? ~r_epoch : r_epoch;
         end
         if (redirect_valid) begin
            r_epoch    <= ~r_epoch;
            r_fetch_pc <= w_redir_addr + ADDR_W'(4);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
         end else begin
            if (w_issue)    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            if (w_push)     r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            if (w_fifo_pop) r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_inst[r_wr_ptr] <= instruction;
         r_mem_pc[r_wr_ptr]   <= r_infl_pc;
      end
   end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue.
// A transaction-level model keeps a queue of {pc, inst} words plus the fetch PC and one pending
// request. It predicts every visible output each cycle.
module tb_riscv_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [31:0] instruction = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  fq_count;

   riscv_fetch_queue #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .icache_addr    (icache_addr),
      .icache_re      (icache_re),
      .instruction    (instruction),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .fq_count       (fq_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc      = RESET_PC;
   logic [31:0] m_infl_pc = '0;
   bit          m_infl    = 1'b0;
   int          n_total   = 0;
   int          n_bad     = 0;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs mid-cycle, check outputs, then advance the model.
   task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
      logic [31:0] tgt;
      bit          e_re, e_valid, resp, byp;
      int          sz;
      ent_t        e;
      @(negedge clk);
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      instruction    = m_infl ? pat(m_infl_pc) : $urandom;
      #1;
      sz  = q.size();
      tgt = {rpc[31:2], 2'b00};
      if (r) begin
         check_val("rst_re", icache_re, 0);
         check_val("rst_valid", out_valid, 0);
         check_val("rst_count", fq_count, 0);
         q.delete();
         m_pc   = RESET_PC;
         m_infl = 1'b0;
         return;
      end
      e_re = rv || ((sz + int'(m_infl)) < DEPTH);
      resp = m_infl && !rv;
`ifdef FETCH_BYPASS_EN
      byp = resp && (sz == 0);
`else
      byp = 1'b0;
`endif
      e_valid = (sz > 0) || byp;
      check_val("re", icache_re, e_re);
      if (e_re) check_val("addr", icache_addr, rv ? tgt : m_pc);
      check_val("valid", out_valid, e_valid);
      check_val("count", fq_count, sz);
      check_val("fq_bound", fq_count <= DEPTH, 1);
      if (e_valid) begin
         if (sz > 0) e = q[0];
         else begin
            e.pc   = m_infl_pc;
            e.inst = instruction;
         end
         check_val("out_pc", out_pc, e.pc);
         check_val("out_inst", out_inst, e.inst);
      end
      if (rv) begin
         q.delete();
         m_infl    = 1'b1;
         m_infl_pc = tgt;
         m_pc      = tgt + 32'd4;
      end else begin
         if (sz > 0 && rdy) void'(q.pop_front());
         if (resp && !(byp && rdy)) q.push_back('{pc: m_infl_pc, inst: instruction});
         m_infl = e_re;
         if (e_re) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
      end
   endtask

   initial begin
      // Reset, then streaming with decode always ready.
      repeat (3) step(1, 0, 0, 1);
      repeat (12) step(0, 0, 0, 1);
      // Decode stall: the FIFO saturates and then drains in order.
      repeat (3) step(1, 0, 0, 0);
      repeat (10) step(0, 0, 0, 0);
      repeat (8) step(0, 0, 0, 1);
      // Redirect to 0x103 while three entries are queued and one fetch is in flight.
      step(1, 0, 0, 0);
      for (int i = 0; i < 20 && !(q.size() == 3 && m_infl); i++) step(0, 0, 0, 0);
      check_val("setup_count3", q.size() == 3 && m_infl, 1);
      step(0, 1, 32'h103, 0);
      repeat (6) step(0, 0, 0, 1);
      // Redirect in the same cycle as a pop.
      repeat (4) step(0, 0, 0, 1);
      step(0, 1, 32'h200, 1);
      repeat (5) step(0, 0, 0, 1);
      // Address wrap.
      step(0, 1, 32'hFFFF_FFFC, 1);
      repeat (6) step(0, 0, 0, 1);
      // Reset the cycle after an issue: the pending response must vanish.
      for (int i = 0; i < 5 && !m_infl; i++) step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      repeat (6) step(0, 0, 0, 1);
      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         step($urandom_range(99) == 0, $urandom_range(19) == 0, rpc, $urandom_range(9) < 7);
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
